pcie_init_sequencer: RTL and testbench

//  Sequences post-power-up release of the fabric and PCIe user logic from the PF_INIT_MONITOR status flags.

---
 rtl/pcie_init_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_pcie_init_sequencer.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/pcie_init_sequencer.sv
// pcie_init_sequencer
//   Releases the user fabric and the PCIe user logic after power-up, driven
//   by the PF_INIT_MONITOR status flags. Each monitor flag is synchronised
//   and must stay high for STABLE_CYCLES before the sequencer moves on.
//   Bring-up order: POR -> device init -> bank calib -> PCIe init -> settle.
//   Each WAIT_* stage has its own timeout.
//
// Ports
//   CLK, RESET           clock and synchronous active-high reset
//   FABRIC_POR_N .. PCIE_INIT_DONE
//                        asynchronous monitor flags
//   RETRY                CLK-domain pulse; leaves FAULT
//   FABRIC_RESET_N       user fabric reset, active low
//   PCIE_CORE_RESET_N    PCIe user-logic reset, active low
//   INIT_DONE            high only in RUN
//   INIT_FAULT           high only in FAULT
//   FAULT_CODE           0 none, 1 dev timeout, 2 calib timeout, 3 pcie timeout
//   STATE                current FSM state, exposed for debug and checkers
//
// Handshake: this block has no valid/ready interfaces. RETRY is a one-cycle
// request. It is acted on only in FAULT and ignored in every other state.
module pcie_init_sequencer #(
  parameter int SYNC_STAGES    = 2,
  parameter int STABLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int SETTLE_CYCLES  = 256,
  parameter int CNT_W          = 24
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       FABRIC_POR_N,
  input  logic       DEVICE_INIT_DONE,
  input  logic       BANK_0_CALIB_STATUS,
  input  logic       BANK_1_CALIB_STATUS,
  input  logic       PCIE_INIT_DONE,
  input  logic       RETRY,
  output logic       FABRIC_RESET_N,
  output logic       PCIE_CORE_RESET_N,
  output logic       INIT_DONE,
  output logic       INIT_FAULT,
  output logic [2:0] FAULT_CODE,
  output logic [2:0] STATE
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_DEV  = 3'd1,
    WAIT_CAL  = 3'd2,
    WAIT_PCIE = 3'd3,
    SETTLE    = 3'd4,
    RUN       = 3'd5,
    FAULT     = 3'd6
  } state_t;

  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);

  // Synchronisers. Only the last stage of each chain is used.
  logic [SYNC_STAGES-1:0] por_sync, dev_sync, cal0_sync, cal1_sync, pcie_sync;
  logic por_s, dev_s, cal_s, pcie_s;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      por_sync  <= '0;
      dev_sync  <= '0;
      cal0_sync <= '0;
      cal1_sync <= '0;
      pcie_sync <= '0;
    end else begin
      por_sync  <= {por_sync[SYNC_STAGES-2:0],  FABRIC_POR_N};
      dev_sync  <= {dev_sync[SYNC_STAGES-2:0],  DEVICE_INIT_DONE};
      cal0_sync <= {cal0_sync[SYNC_STAGES-2:0], BANK_0_CALIB_STATUS};
      cal1_sync <= {cal1_sync[SYNC_STAGES-2:0], BANK_1_CALIB_STATUS};
      pcie_sync <= {pcie_sync[SYNC_STAGES-2:0], PCIE_INIT_DONE};
    end
  end

  assign por_s  = por_sync[SYNC_STAGES-1];
  assign dev_s  = dev_sync[SYNC_STAGES-1];
  assign cal_s  = cal0_sync[SYNC_STAGES-1] & cal1_sync[SYNC_STAGES-1];
  assign pcie_s = pcie_sync[SYNC_STAGES-1];

  state_t           state_q, state_d;
  logic [CNT_W-1:0] stab_cnt, stab_d;
  logic [CNT_W-1:0] tmo_cnt, tmo_d;
  logic [2:0]       code_d;
  logic             cond, stable_hit, timeout_hit;

  always_comb begin
    state_d = state_q;
    stab_d  = stab_cnt;
    tmo_d   = tmo_cnt;
    code_d  = 3'd0;

    case (state_q)
      IDLE:      cond = por_s;
      WAIT_DEV:  cond = dev_s;
      WAIT_CAL:  cond = cal_s;
      WAIT_PCIE: cond = pcie_s;
      default:   cond = 1'b0;
    endcase

    // stable_hit fires on the STABLE_CYCLES-th consecutive high cycle.
    stable_hit  = cond && (stab_cnt == STABLE_LAST);
    timeout_hit = (tmo_cnt == TIMEOUT_LAST);

    case (state_q)
      IDLE: begin
        if (stable_hit) state_d = WAIT_DEV;
        else            stab_d  = cond ? stab_cnt + 1'b1 : '0;
      end
      WAIT_DEV, WAIT_CAL, WAIT_PCIE: begin
        // Advance takes priority over a coincident timeout.
        if (stable_hit) begin
          if (state_q == WAIT_DEV)      state_d = WAIT_CAL;
          else if (state_q == WAIT_CAL) state_d = WAIT_PCIE;
          else                          state_d = SETTLE;
        end else if (timeout_hit) begin
          state_d = FAULT;
          if (state_q == WAIT_DEV)      code_d = 3'd1;
          else if (state_q == WAIT_CAL) code_d = 3'd2;
          else                          code_d = 3'd3;
        end else begin
          stab_d = cond ? stab_cnt + 1'b1 : '0;
          tmo_d  = tmo_cnt + 1'b1;
        end
      end
      SETTLE: begin
        if (tmo_cnt == SETTLE_LAST) state_d = RUN;
        else                        tmo_d   = tmo_cnt + 1'b1;
      end
      RUN: begin
        state_d = RUN;
      end
      FAULT: begin
        code_d = FAULT_CODE;
        if (RETRY) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Loss of a prerequisite overrides normal progress.
    // Calibration is watched only in WAIT_CAL, so a later calib drop is not a loss.
    if (state_q inside {WAIT_DEV, WAIT_CAL, WAIT_PCIE, SETTLE, RUN}) begin
      if (!por_s)
        state_d = IDLE;
      else if (!dev_s && state_q != WAIT_DEV)
        state_d = IDLE;
      else if (!pcie_s && (state_q == SETTLE || state_q == RUN))
        state_d = WAIT_PCIE;
    end

    if (state_d != FAULT) code_d = 3'd0;

    if (state_d != state_q) begin
      stab_d = '0;
      tmo_d  = '0;
    end
  end

  // Outputs are registered from the next state, so they change on the same edge as STATE.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q           <= IDLE;
      stab_cnt          <= '0;
      tmo_cnt           <= '0;
      FABRIC_RESET_N    <= 1'b0;
      PCIE_CORE_RESET_N <= 1'b0;
      INIT_DONE         <= 1'b0;
      INIT_FAULT        <= 1'b0;
      FAULT_CODE        <= 3'd0;
    end else begin
      state_q           <= state_d;
      stab_cnt          <= stab_d;
      tmo_cnt           <= tmo_d;
      FABRIC_RESET_N    <= (state_d == WAIT_PCIE) || (state_d == SETTLE) || (state_d == RUN);
      PCIE_CORE_RESET_N <= (state_d == SETTLE) || (state_d == RUN);
      INIT_DONE         <= (state_d == RUN);
      INIT_FAULT        <= (state_d == FAULT);
      FAULT_CODE        <= code_d;
    end
  end

  assign STATE = state_q;

endmodule

// File: tb/tb_pcie_init_sequencer.sv
// tb_pcie_init_sequencer
//   Directed bench for pcie_init_sequencer with SYNC=2, STABLE=4, TIMEOUT=100
//   and SETTLE=8. Inputs change 1 time unit after a rising edge. Outputs are
//   sampled at the same point, after the next edge.
module tb_pcie_init_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       por_n, dev_done, cal0, cal1, pcie_done, retry;
  logic       fabric_reset_n, pcie_core_reset_n, init_done, init_fault;
  logic [2:0] fault_code, state;
  logic [9:0] obs_vec;

  int tests = 0;
  int fails = 0;
  logic [9:0] exp_q[$];

  pcie_init_sequencer #(
    .SYNC_STAGES(2), .STABLE_CYCLES(4), .TIMEOUT_CYCLES(100),
    .SETTLE_CYCLES(8), .CNT_W(24)
  ) dut (
    .CLK(clk), .RESET(reset),
    .FABRIC_POR_N(por_n), .DEVICE_INIT_DONE(dev_done),
    .BANK_0_CALIB_STATUS(cal0), .BANK_1_CALIB_STATUS(cal1),
    .PCIE_INIT_DONE(pcie_done), .RETRY(retry),
    .FABRIC_RESET_N(fabric_reset_n), .PCIE_CORE_RESET_N(pcie_core_reset_n),
    .INIT_DONE(init_done), .INIT_FAULT(init_fault),
    .FAULT_CODE(fault_code), .STATE(state)
  );

  assign obs_vec = {state, fabric_reset_n, pcie_core_reset_n, init_done, init_fault, fault_code};

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Expected output bundle for a given state and fault code.
  function automatic logic [9:0] exp_vec(input logic [2:0] s, input logic [2:0] code);
    logic frn, prn, done, flt;
    frn  = (s == 3'd3) || (s == 3'd4) || (s == 3'd5);
    prn  = (s == 3'd4) || (s == 3'd5);
    done = (s == 3'd5);
    flt  = (s == 3'd6);
    return {s, frn, prn, done, flt, code};
  endfunction

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] bringup_state(input int n);
    if (n < 6)       return 3'd0;
    else if (n < 10) return 3'd1;
    else if (n < 14) return 3'd2;
    else if (n < 18) return 3'd3;
    else if (n < 26) return 3'd4;
    else             return 3'd5;
  endfunction

  initial begin
    reset = 1'b1; retry = 1'b0;
    por_n = 1'b0; dev_done = 1'b0; cal0 = 1'b0; cal1 = 1'b0; pcie_done = 1'b0;
    ticks(2);
    chk("reset_state", obs_vec, exp_vec(3'd0, 3'd0));

    // 1: nominal bring-up, all inputs high at t0; INIT_DONE at t0+26
    reset = 1'b0;
    por_n = 1'b1; dev_done = 1'b1; cal0 = 1'b1; cal1 = 1'b1; pcie_done = 1'b1;
    for (int n = 1; n <= 27; n++) exp_q.push_back(exp_vec(bringup_state(n), 3'd0));
    while (exp_q.size() > 0) begin
      tick();
      chk("bringup", obs_vec, exp_q.pop_front());
    end

    // 4: one-cycle PCIE_INIT_DONE drop in RUN
    for (int i = 1; i <= 16; i++) begin
      pcie_done = (i == 1) ? 1'b0 : 1'b1;
      tick();
      if (i <= 2)       chk("pcie_drop", obs_vec, exp_vec(3'd5, 3'd0));
      else if (i <= 6)  chk("pcie_drop", obs_vec, exp_vec(3'd3, 3'd0));
      else if (i <= 14) chk("pcie_drop", obs_vec, exp_vec(3'd4, 3'd0));
      else              chk("pcie_drop", obs_vec, exp_vec(3'd5, 3'd0));
    end

    // 5: POR drop in RUN -> IDLE exactly SYNC+1 edges later
    por_n = 1'b0;
    tick(); chk("por_drop_e1", obs_vec, exp_vec(3'd5, 3'd0));
    tick(); chk("por_drop_e2", obs_vec, exp_vec(3'd5, 3'd0));
    tick(); chk("por_drop_e3", obs_vec, exp_vec(3'd0, 3'd0));
    tick(); chk("por_drop_hold", obs_vec, exp_vec(3'd0, 3'd0));

    // 2: glitch on DEVICE_INIT_DONE while in WAIT_DEV (BANK_1 low for test 3)
    dev_done = 1'b0; cal1 = 1'b0; por_n = 1'b1;
    ticks(5);
    chk("por_idle_dwell", obs_vec, exp_vec(3'd0, 3'd0));
    tick();
    chk("enter_wait_dev", obs_vec, exp_vec(3'd1, 3'd0));
    for (int i = 1; i <= 10; i++) begin
      dev_done = (i == 4) ? 1'b0 : 1'b1;
      tick();
      if (i < 10) chk("dev_glitch", obs_vec, exp_vec(3'd1, 3'd0));
      else        chk("dev_glitch_adv", obs_vec, exp_vec(3'd2, 3'd0));
    end

    // 3: calibration timeout -> FAULT code 2 on the 100th cycle
    ticks(99);
    chk("cal_tmo_minus1", obs_vec, exp_vec(3'd2, 3'd0));
    tick();
    chk("cal_tmo_fault", obs_vec, exp_vec(3'd6, 3'd2));
    por_n = 1'b0;
    ticks(4);
    chk("fault_ignores_loss", obs_vec, exp_vec(3'd6, 3'd2));
    retry = 1'b1;
    tick();
    retry = 1'b0;
    chk("retry_to_idle", obs_vec, exp_vec(3'd0, 3'd0));
    tick();
    chk("retry_idle_hold", obs_vec, exp_vec(3'd0, 3'd0));

    // 6: RETRY outside FAULT ignored; RESET mid-SETTLE
    por_n = 1'b1; cal1 = 1'b1;
    ticks(20);
    chk("reach_settle", obs_vec, exp_vec(3'd4, 3'd0));
    retry = 1'b1;
    tick();
    retry = 1'b0;
    chk("retry_in_settle", obs_vec, exp_vec(3'd4, 3'd0));
    reset = 1'b1;
    tick();
    chk("reset_mid_settle", obs_vec, exp_vec(3'd0, 3'd0));
    tick();
    chk("reset_held", obs_vec, exp_vec(3'd0, 3'd0));
    reset = 1'b0;
    ticks(25);
    chk("rebringup_settle", obs_vec, exp_vec(3'd4, 3'd0));
    tick();
    chk("rebringup_run", obs_vec, exp_vec(3'd5, 3'd0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
